video_to_fifo_ctrl: RTL
=======================

VIDEO_TO_FIFO_CTRL -- requirements
Module: video_to_fifo_ctrl

Interface
REQ-001 Parameter: PEND_W, default 4, width of the pending line-burst counter; the counter saturates at 2^PEND_W-1.
REQ-002 Clock and reset: one clock and one reset only; reset is asynchronous and active-low; all flops clear immediately on video_rst_n low.
REQ-003 video_clk  input  1  pixel clock; all logic on its rising edge.
REQ-004 video_rst_n  input  1  asynchronous active-low reset.
REQ-005 video_vs_in  input  1  active-high vertical sync.
REQ-006 video_hs_in  input  1  active-high horizontal sync; carried for timing alignment only, never used as a data qualifier.
REQ-007 video_de_in  input  1  active-high data enable.
REQ-008 video_data_in  input  24  RGB888 pixel, valid when video_de_in=1.
REQ-009 fifo_data_out  output  128  packed word to the write FIFO.
REQ-010 fifo_wr_en  output  1  one-cycle write strobe for fifo_data_out.
REQ-011 fifo_full  input  1  write FIFO full.
REQ-012 AXI_FULL_BURST_VALID  output  1  request for one line write burst to DDR.
REQ-013 AXI_FULL_BURST_READY  input  1  burst engine accepts the request.
REQ-014 frame_start  output  1  one-cycle pulse marking a new frame, used to rewind the DDR write address.
REQ-015 overflow  output  1  sticky error flag.

Function
REQ-016 Input register: vs, de, and data are sampled into delay registers; frame start is detected on the rising edge of vs_in, and line end on the falling edge of de_in (de_d1=1, de_in=0).
REQ-017 Capture gating: after reset, capture is disabled until the first vs_in rising edge; pixels are ignored and no words or requests are produced before that edge.
REQ-018 Frame start pulse: on each vs_in rising edge, frame_start is high for exactly the next cycle.
REQ-019 Frame start clearing: each vs_in rising edge clears the 2-bit slot counter, the partial-word register, the pending counter, and overflow; AXI_FULL_BURST_VALID drops to 0 on the next cycle.
REQ-020 Packing: each sampled pixel with de_in=1 goes into slot shift_cnt, and shift_cnt then increments and wraps 3 to 0.
REQ-021 Word layout: slot 0 is at [96+:24], slot 1 at [64+:24], slot 2 at [32+:24], and slot 3 at [0+:24]; bits [127:120], [95:88], [63:56], and [31:24] are always 0.
REQ-022 Full-word write: on the edge that samples slot 3, fifo_data_out takes the complete word and fifo_wr_en=1 in the following cycle only, giving a one-cycle latency from the 4th pixel to the write strobe.
REQ-023 Partial-word flush: at line end with shift_cnt!=0, the partial word is written with unfilled slots set to 0, using the same one-cycle strobe, and shift_cnt returns to 0.
REQ-024 Line end with no partial word: at line end with shift_cnt=0, no extra word is written.
REQ-025 FIFO full: if fifo_full=1 in the cycle fifo_wr_en would assert, fifo_wr_en stays 0, the word is dropped, and overflow is set.
REQ-026 Pending counter: each line end increments the pending counter; each cycle with VALID&READY decrements it; a line end and a handshake in the same cycle leave it unchanged.
REQ-027 Pending saturation: an increment at 2^PEND_W-1 is lost and sets overflow.
REQ-028 VALID generation: AXI_FULL_BURST_VALID is a register equal to (pending!=0), so VALID rises the cycle after the line end and stays high while READY=0.
REQ-029 VALID after handshake: VALID deasserts after the handshake that brings pending to 0.
REQ-030 Overflow clearing: overflow stays set until the next frame start or reset.

Reset
REQ-031 Output reset values: while video_rst_n=0, fifo_data_out=0, fifo_wr_en=0, AXI_FULL_BURST_VALID=0, frame_start=0, and overflow=0.
REQ-032 Internal reset values: while video_rst_n=0, shift_cnt=0, pending=0, capture is disabled, and the delay registers are 0.
REQ-033 Reset mid-line: a reset asserted in the middle of a line discards the partial word and pending requests; after release, the block waits for the next vs_in rising edge before capturing.

Verification
REQ-034 Basic packing: vs pulse, then 8 pixels 0x000001..0x000008 with de=1 -> frame_start pulses once; two writes: 0x00000001_00000002_00000003_00000004, then 0x00000005_00000006_00000007_00000008; fifo_wr_en is high one cycle after pixels 4 and 8; VALID rises the cycle after de falls.
REQ-035 Partial flush: line of 6 pixels 0xAAAAAA..., with last two 0x111111, 0x222222 -> second word is 0x00111111_00222222_00000000_00000000; shift_cnt is 0 at the start of the next line.
REQ-036 Pending count: three short lines with READY held 0, then READY=1 for 3 cycles -> VALID stays high through 3 handshakes, then 0; a line end coinciding with a handshake leaves the count unchanged.
REQ-037 FIFO full: fifo_full=1 during the 4th pixel's write cycle -> no strobe, overflow=1; overflow clears on the next vs rising edge.
REQ-038 Pre-sync gating: pixels applied after reset release and before any vs pulse -> no fifo_wr_en and no VALID.
REQ-039 Reset mid-line: reset asserted after 2 pixels of a line -> all outputs 0 immediately; no flush word after release.

Source files
------------

// File: rtl/video_to_fifo_ctrl_if.sv
// Bus bundle between the video front end, the write FIFO and the DDR burst engine.
// Burst handshake: VALID/READY transfer one line-burst request on every rising
// clock edge where both are high; once raised, VALID stays high until that transfer.
interface video_to_fifo_ctrl_if;
  logic         video_vs_in;
  logic         video_hs_in;
  logic         video_de_in;
  logic [23:0]  video_data_in;
  logic [127:0] fifo_data_out;
  logic         fifo_wr_en;
  logic         fifo_full;
  logic         AXI_FULL_BURST_VALID;
  logic         AXI_FULL_BURST_READY;
  logic         frame_start;
  logic         overflow;

  modport slave (
    input  video_vs_in, video_hs_in, video_de_in, video_data_in,
    input  fifo_full, AXI_FULL_BURST_READY,
    output fifo_data_out, fifo_wr_en, AXI_FULL_BURST_VALID, frame_start, overflow
  );

  modport master (
    output video_vs_in, video_hs_in, video_de_in, video_data_in,
    output fifo_full, AXI_FULL_BURST_READY,
    input  fifo_data_out, fifo_wr_en, AXI_FULL_BURST_VALID, frame_start, overflow
  );
endinterface

// File: rtl/video_to_fifo_ctrl.sv
// Packs RGB888 pixels four-per-128-bit word into a write FIFO and counts completed
// lines as pending DDR burst requests; capture is armed by the first vsync edge.
module video_to_fifo_ctrl #(
  parameter int PEND_W = 4
) (
  input  logic               video_clk,
  input  logic               video_rst_n,
  video_to_fifo_ctrl_if.slave bus,
  output logic [1:0]         dbg_shift_cnt,
  output logic [PEND_W-1:0]  dbg_pending,
  output logic               dbg_capture_en,
  output logic               dbg_hs_d1
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = {{(PEND_W-1){1'b0}}, 1'b1};

  logic              vs_d1, de_d1, hs_d1;
  logic              capture_en;
  logic [1:0]        shift_cnt;
  logic [23:0]       slot0, slot1, slot2;
  logic [PEND_W-1:0] pending;
  logic              wr_req, valid_q, frame_start_q, overflow_q;
  logic [127:0]      data_q;

  logic              vs_rise, line_end, pix, hs_ok, pend_sat, drop;
  logic [PEND_W-1:0] pend_next;
  logic [127:0]      full_word, partial_word;

  assign vs_rise  = bus.video_vs_in & ~vs_d1;
  assign line_end = capture_en & de_d1 & ~bus.video_de_in;
  assign pix      = capture_en & bus.video_de_in;
  assign hs_ok    = valid_q & bus.AXI_FULL_BURST_READY;
  assign pend_sat = line_end & ~hs_ok & (pending == PEND_MAX);
  // The write strobe is gated by the live full flag; a gated strobe is a lost word.
  assign drop     = wr_req & bus.fifo_full;

  // Unfilled slots are already zero because the slot registers clear after each write.
  assign full_word    = {8'h00, slot0, 8'h00, slot1, 8'h00, slot2, 8'h00, bus.video_data_in};
  assign partial_word = {8'h00, slot0, 8'h00, slot1, 8'h00, slot2, 32'h0};

  always_comb begin
    pend_next = pending;
    case ({line_end, hs_ok})
      2'b10:   pend_next = pend_sat ? pending : pending + PEND_ONE;
      2'b01:   pend_next = pending - PEND_ONE;
      default: pend_next = pending;
    endcase
  end

  always_ff @(posedge video_clk or negedge video_rst_n) begin
    if (!video_rst_n) begin
      vs_d1         <= 1'b0;
      de_d1         <= 1'b0;
      hs_d1         <= 1'b0;
      capture_en    <= 1'b0;
      shift_cnt     <= 2'd0;
      slot0         <= 24'h0;
      slot1         <= 24'h0;
      slot2         <= 24'h0;
      pending       <= '0;
      wr_req        <= 1'b0;
      valid_q       <= 1'b0;
      frame_start_q <= 1'b0;
      overflow_q    <= 1'b0;
      data_q        <= 128'h0;
    end else begin
      vs_d1         <= bus.video_vs_in;
      de_d1         <= bus.video_de_in;
      hs_d1         <= bus.video_hs_in;
      frame_start_q <= vs_rise;
      wr_req        <= 1'b0;
      if (vs_rise) begin
        // New frame: rewind everything, pixels on this edge belong to no line yet.
        capture_en <= 1'b1;
        shift_cnt  <= 2'd0;
        slot0      <= 24'h0;
        slot1      <= 24'h0;
        slot2      <= 24'h0;
        pending    <= '0;
        valid_q    <= 1'b0;
        overflow_q <= 1'b0;
      end else begin
        if (drop || pend_sat) overflow_q <= 1'b1;
        pending <= pend_next;
        valid_q <= (pend_next != '0);
        if (pix) begin
          shift_cnt <= shift_cnt + 2'd1;
          case (shift_cnt)
            2'd0: slot0 <= bus.video_data_in;
            2'd1: slot1 <= bus.video_data_in;
            2'd2: slot2 <= bus.video_data_in;
            2'd3: begin
              data_q <= full_word;
              wr_req <= 1'b1;
              slot0  <= 24'h0;
              slot1  <= 24'h0;
              slot2  <= 24'h0;
            end
            default: ;
          endcase
        end else if (line_end && shift_cnt != 2'd0) begin
          data_q    <= partial_word;
          wr_req    <= 1'b1;
          shift_cnt <= 2'd0;
          slot0     <= 24'h0;
          slot1     <= 24'h0;
          slot2     <= 24'h0;
        end
      end
    end
  end

  assign bus.fifo_data_out        = data_q;
  assign bus.fifo_wr_en           = wr_req & ~bus.fifo_full;
  assign bus.AXI_FULL_BURST_VALID = valid_q;
  assign bus.frame_start          = frame_start_q;
  assign bus.overflow             = overflow_q;

  assign dbg_shift_cnt  = shift_cnt;
  assign dbg_pending    = pending;
  assign dbg_capture_en = capture_en;
  assign dbg_hs_d1      = hs_d1;

endmodule
